stream_comp_invoke: RTL
=======================

# stream_comp_invoke

Firing (invoke) module for the stream_comp actor: the counterpart to its enable module. Once the scheduler has seen the actor enabled and pulses `invoke`, this block runs one firing in the requested mode. The modes are SETUP_COMP, COMP and OUTPUT. A firing reads tokens from the data, length and command FIFOs, folds them into one result, or writes that result to the output FIFO. It then reports firing-complete and the next mode back to the scheduler.

## Interface
Parameters:
- `size`, 3: tokens consumed per FIFO per SETUP_COMP firing.
- `width`, 16: token width on all FIFOs, in bits. Data is two's-complement signed.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `invoke`  in  1  one-cycle start pulse. Ignored while a firing is in progress.
- `next_mode_in`  in  2  mode to fire. 00 SETUP_COMP, 01 COMP, 10 OUTPUT, 11 invalid.
- `rd_data`, `rd_length`, `rd_command`  out  1  read strobes to the input FIFOs.
- `data_in`, `length_in`, `command_in`  in  width  FIFO read data, valid one cycle after the strobe.
- `wr_out`  out  1  write strobe to the output FIFO.
- `data_out`  out  width  result token, valid while `wr_out` is high.
- `FC`  out  1  firing-complete, one-cycle pulse.
- `next_mode_out`  out  2  mode for the next firing. Valid from the `FC` cycle onward; holds until the next `FC`.

## Operation
- Firing FSM states: IDLE, SETUP_RD, COMP_RUN, OUT_WR, DONE.
  - `invoke` is sampled only in IDLE.
  - `invoke` selects the next state from `next_mode_in`.
- SETUP_COMP:
  - Asserts all three read strobes together for `size` consecutive cycles.
  - Captures token i into register arrays d[i], l[i], c[i], one cycle after strobe i.
  - Clears the accumulator `acc` to 0.
  - `next_mode_out` = COMP.
- COMP:
  - Processes one element per cycle, for i = 0..size-1.
  - If l[i] == 0, the element is skipped and `acc` is unchanged.
  - Otherwise c[i][1:0] selects the operation: 00 acc+d[i], 01 acc-d[i], 10 max(acc,d[i]), 11 min(acc,d[i]).
  - Upper bits of c[i] are ignored.
  - `next_mode_out` = OUTPUT.
- OUTPUT:
  - One cycle with `wr_out` = 1 and `data_out` = acc.
  - `next_mode_out` = SETUP_COMP.
  - The enable module guarantees free space; no full check is made here.
- Invalid mode 11:
  - No FIFO strobes.
  - `FC` pulses.
  - `next_mode_out` = SETUP_COMP.
- Arithmetic:
  - Signed, width-bit.
  - Overflow behaviour is set by the Configuration macro.
  - max and min compare signed values.

## Timing
Cycle 0 is the cycle in which `invoke` is sampled high.
- SETUP_COMP:
  - Strobes are high in cycles 1..size.
  - Captures happen in cycles 2..size+1.
  - `FC` is high in cycle size+2.
- COMP:
  - Element i updates `acc` at the end of cycle i+1.
  - `FC` is high in cycle size+1.
- OUTPUT: `wr_out`, `data_out` and `FC` are all high in cycle 1.
- Invalid mode: `FC` is high in cycle 1.
- The block returns to IDLE in the cycle after `FC`. A new `invoke` is accepted there at the earliest (back-to-back firings).
- `invoke` while busy is dropped, with no effect on the current firing.
- Reset values:
  - All strobes, `FC` and `data_out` = 0.
  - `next_mode_out` = 00.
  - FSM in IDLE.
  - `acc`, d, l and c cleared.
- Reset mid-firing: the firing is aborted and strobes are low the cycle after `rst`. No `FC` is issued; tokens already popped are lost.

## Configuration
- `STREAM_COMP_SATURATE_EN`:
  - Defined: add and sub clamp to the signed range [-2^(width-1), 2^(width-1)-1].
  - Undefined: add and sub wrap modulo 2^width.
  - max and min are unaffected in both builds.

## Test plan
Defaults are size=3, width=16 unless a scenario says otherwise.
- Reset: hold `rst` 2 cycles with `invoke` high. Every output must be 0, `next_mode_out` = 00, and there is no `FC` until reset is released and a new `invoke` arrives.
- Add path: run SETUP_COMP, COMP and OUTPUT with data 5,7,-2, length 1,1,1, command 0,0,0.
  - Output is `data_out` = 10.
  - `FC` lands at cycles 5, 4 and 1 of the respective firings.
  - `next_mode_out` reads 01, 10, 00 in turn.
- Mixed ops and skip: data 10,3,20, command add,sub,max, length 1,1,1 gives 20. The same data with length 1,1,0 gives 7.
- Overflow: data 32767,1,0, all add, all length 1. Output is 32767 with `STREAM_COMP_SATURATE_EN` defined, -32768 without.
- Reset mid-SETUP_COMP after 2 strobes:
  - Strobes drop the next cycle and no `FC` is issued.
  - A fresh SETUP_COMP firing then reads 3 new tokens correctly.
- Busy and invalid mode:
  - A second `invoke` during COMP is ignored and `FC` still lands at cycle 4.
  - `next_mode_in` = 11 gives `FC` at cycle 1, no strobes, `next_mode_out` = 00.

Source files
------------

// File: rtl/stream_comp_invoke_if.sv
// Firing-side bus of the stream_comp actor: scheduler handshake, input FIFO reads, output FIFO write.
// No latency of its own; pure signal bundle.
// No backpressure: reads and writes rely on the enable module having checked FIFO occupancy.
interface stream_comp_invoke_if #(
  parameter int width = 16
);
  logic             invoke;
  logic [1:0]       next_mode_in;
  logic             rd_data;
  logic             rd_length;
  logic             rd_command;
  logic [width-1:0] data_in;
  logic [width-1:0] length_in;
  logic [width-1:0] command_in;
  logic             wr_out;
  logic [width-1:0] data_out;
  logic             FC;
  logic [1:0]       next_mode_out;

  // Scheduler / FIFO side
  modport master (
    output invoke, next_mode_in, data_in, length_in, command_in,
    input  rd_data, rd_length, rd_command, wr_out, data_out, FC, next_mode_out
  );

  // Firing block side
  modport slave (
    input  invoke, next_mode_in, data_in, length_in, command_in,
    output rd_data, rd_length, rd_command, wr_out, data_out, FC, next_mode_out
  );
endinterface

// File: rtl/stream_comp_invoke.sv
// Invoke block of stream_comp: runs one SETUP_COMP / COMP / OUTPUT firing per invoke pulse.
// Latency: SETUP_COMP FC at cycle size+2, COMP at size+1, OUTPUT and invalid mode at cycle 1.
// No backpressure; invoke is dropped while busy. STREAM_COMP_SATURATE_EN selects clamping add/sub.
module stream_comp_invoke #(
  parameter int size  = 3,
  parameter int width = 16
) (
  input logic                 clk,
  input logic                 rst,
  stream_comp_invoke_if.slave bus
);
  localparam int CW = $clog2(size + 1);
  localparam int IW = (size > 1) ? $clog2(size) : 1;
  localparam logic [CW-1:0] SIZE_C = CW'(size);
  localparam logic [CW-1:0] LAST_C = CW'(size - 1);

  localparam logic [1:0] MODE_SETUP  = 2'b00;
  localparam logic [1:0] MODE_COMP   = 2'b01;
  localparam logic [1:0] MODE_OUTPUT = 2'b10;

  typedef enum logic [2:0] {IDLE, SETUP_RD, COMP_RUN, OUT_WR, DONE} state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic                    rd_q;
  logic                    wr_q;
  logic [width-1:0]        dout_q;
  logic                    fc_q;
  logic [1:0]              nm_q;
  logic signed [width-1:0] acc_q;
  logic [width-1:0]        d_q [size];
  logic [width-1:0]        l_q [size];
  logic [width-1:0]        c_q [size];

  logic [IW-1:0]           elem_idx;
  logic [CW-1:0]           cnt_m1;
  logic [IW-1:0]           cap_idx;
  logic signed [width-1:0] d_sel;
  logic signed [width-1:0] acc_arith;
  logic signed [width-1:0] acc_d;
  logic                    unused_cmd_hi;

  assign elem_idx = cnt_q[IW-1:0];
  assign cnt_m1   = cnt_q - 1'b1;
  assign cap_idx  = cnt_m1[IW-1:0];

`ifdef STREAM_COMP_SATURATE_EN
  localparam logic signed [width-1:0] SMAX = {1'b0, {(width-1){1'b1}}};
  localparam logic signed [width-1:0] SMIN = {1'b1, {(width-1){1'b0}}};
  logic [width:0] sum_w;

  // Add/sub one guard bit wide, then clamp when the guard and sign bits disagree
  always_comb begin
    sum_w = '0;
    if (c_q[elem_idx][0]) sum_w = {acc_q[width-1], acc_q} - {d_sel[width-1], d_sel};
    else                  sum_w = {acc_q[width-1], acc_q} + {d_sel[width-1], d_sel};
    if (sum_w[width] != sum_w[width-1]) acc_arith = sum_w[width] ? SMIN : SMAX;
    else                                acc_arith = sum_w[width-1:0];
  end
`else
  // Add/sub wrapping modulo 2^width
  always_comb begin
    acc_arith = '0;
    if (c_q[elem_idx][0]) acc_arith = acc_q - d_sel;
    else                  acc_arith = acc_q + d_sel;
  end
`endif

  // Fold of the current element into the accumulator; zero length skips it
  always_comb begin
    d_sel = d_q[elem_idx];
    acc_d = acc_q;
    if (l_q[elem_idx] != '0) begin
      case (c_q[elem_idx][1:0])
        2'b10:   acc_d = (d_sel > acc_q) ? d_sel : acc_q;
        2'b11:   acc_d = (d_sel < acc_q) ? d_sel : acc_q;
        default: acc_d = acc_arith;
      endcase
    end
  end

  // Only the two low command bits select an operation; the rest are carried but unused
  always_comb begin
    unused_cmd_hi = 1'b0;
    for (int i = 0; i < size; i++) unused_cmd_hi = unused_cmd_hi ^ (^c_q[i][width-1:2]);
  end

  // Firing FSM with registered strobes, FC and next mode
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      fc_q    <= 1'b0;
      nm_q    <= MODE_SETUP;
      acc_q   <= '0;
      for (int i = 0; i < size; i++) begin
        d_q[i] <= '0;
        l_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      fc_q   <= 1'b0;
      wr_q   <= 1'b0;
      dout_q <= '0;
      case (state_q)
        IDLE: begin
          if (bus.invoke) begin
            cnt_q <= '0;
            case (bus.next_mode_in)
              MODE_SETUP: begin
                state_q <= SETUP_RD;
                rd_q    <= 1'b1;
                acc_q   <= '0;
              end
              MODE_COMP: state_q <= COMP_RUN;
              MODE_OUTPUT: begin
                state_q <= OUT_WR;
                wr_q    <= 1'b1;
                dout_q  <= acc_q;
                fc_q    <= 1'b1;
                nm_q    <= MODE_SETUP;
              end
              default: begin
                state_q <= DONE;
                fc_q    <= 1'b1;
                nm_q    <= MODE_SETUP;
              end
            endcase
          end
        end
        SETUP_RD: begin
          // cnt_q tracks the strobe index issued last cycle; its data is on the bus now
          cnt_q <= cnt_q + 1'b1;
          rd_q  <= (cnt_q < LAST_C);
          if (cnt_q != '0) begin
            d_q[cap_idx] <= bus.data_in;
            l_q[cap_idx] <= bus.length_in;
            c_q[cap_idx] <= bus.command_in;
          end
          if (cnt_q == SIZE_C) begin
            state_q <= DONE;
            fc_q    <= 1'b1;
            nm_q    <= MODE_COMP;
          end
        end
        COMP_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_C) begin
            state_q <= DONE;
            fc_q    <= 1'b1;
            nm_q    <= MODE_OUTPUT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rd_data       = rd_q;
  assign bus.rd_length     = rd_q;
  assign bus.rd_command    = rd_q;
  assign bus.wr_out        = wr_q;
  assign bus.data_out      = dout_q;
  assign bus.FC            = fc_q;
  assign bus.next_mode_out = nm_q;
endmodule
